// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer owning the MIPS HI/LO
// registers. Shift-add multiply and restoring divide, STEPS steps per cycle.
module muldiv_ctrl #(
   parameter int unsigned STEPS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] mf_data,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned N = 32 / STEPS;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   // MUL: {acc, multiplier}; DIV: {remainder, quotient}
   logic [63:0] p_q, p_d;
   // multiplicand (MUL) or divisor (DIV) magnitude
   logic [31:0] m_q, m_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   // neg_p for MUL, neg_q for DIV
   logic        neg_a_q, neg_a_d;
   logic        neg_r_q, neg_r_d;

   logic        accept;
   logic        is_signed;
   logic [31:0] mag_s, mag_t;
   logic [63:0] p_step;
   logic [32:0] t;

   assign stall  = op_valid & (state_q != IDLE);
   assign accept = op_valid & ~stall;
   assign busy   = (state_q != IDLE);
   assign done   = (state_q == FIXUP);
   assign hi     = hi_q;
   assign lo     = lo_q;

   // Operand sign handling: MULT (0) and DIV (2) are the signed ops
   assign is_signed = ~op_code[2] & ~op_code[0];
   assign mag_s     = (is_signed && rs_data[31]) ? -rs_data : rs_data;
   assign mag_t     = (is_signed && rt_data[31]) ? -rt_data : rt_data;

   // MF read mux from registered HI/LO
   always_comb begin
      mf_data = '0;
      if (op_code == 3'd6) mf_data = hi_q;
      else if (op_code == 3'd7) mf_data = lo_q;
   end

   // STEPS iterations of shift-add multiply or restoring divide
   always_comb begin
      p_step = p_q;
      t      = '0;
      for (int unsigned i = 0; i < STEPS; i++) begin
         if (state_q == MUL) begin
            // 33-bit sum keeps the carry that shifts into acc's MSB
            t      = {1'b0, p_step[63:32]} + (p_step[0] ? {1'b0, m_q} : 33'd0);
            p_step = {t, p_step[31:1]};
         end else begin
            // p_step[63:31] is the remainder after the left shift
            t = p_step[63:31] - {1'b0, m_q};
            if (!t[32]) p_step = {t[31:0], p_step[30:0], 1'b1};
            else        p_step = {p_step[62:0], 1'b0};
         end
      end
   end

   // Next-state, datapath and HI/LO update
   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      p_d      = p_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_a_d  = neg_a_q;
      neg_r_d  = neg_r_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               unique case (op_code)
                  3'd0, 3'd1: begin
                     m_d      = mag_s;
                     p_d      = {32'b0, mag_t};
                     neg_a_d  = is_signed & (rs_data[31] ^ rt_data[31]);
                     neg_r_d  = 1'b0;
                     is_div_d = 1'b0;
                     cnt_d    = '0;
                     state_d  = MUL;
                  end
                  3'd2, 3'd3: begin
                     is_div_d = 1'b1;
                     cnt_d    = '0;
                     if (rt_data == '0) begin
                        // forced result rides through FIXUP with no sign fixup
                        p_d     = {rs_data, 32'hFFFF_FFFF};
                        neg_a_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = FIXUP;
                     end else begin
                        m_d     = mag_t;
                        p_d     = {32'b0, mag_s};
                        neg_a_d = is_signed & (rs_data[31] ^ rt_data[31]);
                        neg_r_d = is_signed & rs_data[31];
                        state_d = DIV;
                     end
                  end
                  3'd4:       hi_d = rs_data;
                  3'd5:       lo_d = rs_data;
                  3'd6, 3'd7: ;
               endcase
            end
         end
         MUL, DIV: begin
            p_d   = p_step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(N - 1)) state_d = FIXUP;
         end
         FIXUP: begin
            if (is_div_q) begin
               lo_d = neg_a_q ? -p_q[31:0]  : p_q[31:0];
               hi_d = neg_r_q ? -p_q[63:32] : p_q[63:32];
            end else begin
               {hi_d, lo_d} = neg_a_q ? -p_q : p_q;
            end
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         p_q      <= '0;
         m_q      <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_a_q  <= 1'b0;
         neg_r_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         p_q      <= p_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_a_q  <= neg_a_d;
         neg_r_q  <= neg_r_d;
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed table-driven bench for muldiv_ctrl, with
// STEPS = 1 and STEPS = 4 instances sharing the same stimulus.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] rs_data, rt_data;
   logic        stall1, busy1, done1, stall4, busy4, done4;
   logic [31:0] mf1, hi1, lo1, mf4, hi4, lo4;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t vecs [12];

   always #5 clk = ~clk;

   muldiv_ctrl #(.STEPS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
      .rs_data(rs_data), .rt_data(rt_data), .stall(stall1), .busy(busy1),
      .done(done1), .mf_data(mf1), .hi(hi1), .lo(lo1)
   );

   muldiv_ctrl #(.STEPS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
      .rs_data(rs_data), .rt_data(rt_data), .stall(stall4), .busy(busy4),
      .done(done4), .mf_data(mf4), .hi(hi4), .lo(lo4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present an op at the negedge; it is accepted at the following posedge
   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = op;
      rs_data  = a;
      rt_data  = b;
      #1;
      chk("issue_stall", {31'b0, stall1}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, dn, dlast, s1, s4, k;
      logic got4;
      logic [31:0] mf4v;

      vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
      vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
      vecs[2]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
      vecs[3]  = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33};
      vecs[4]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 33};
      vecs[5]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
      vecs[6]  = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        33};
      vecs[7]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
      vecs[8]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
      vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33};
      vecs[10] = '{3'd2, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1};
      vecs[11] = '{3'd3, 32'h0000_0003, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 33};

      // Reset state
      rst_n = 1'b0; op_valid = 1'b0; op_code = 3'd6; rs_data = '0; rt_data = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy",  {31'b0, busy1},  32'd0);
      chk("rst_done",  {31'b0, done1},  32'd0);
      chk("rst_hi",    hi1, 32'd0);
      chk("rst_lo",    lo1, 32'd0);
      chk("rst_stall", {31'b0, stall1}, 32'd0);
      chk("rst_mf",    mf1, 32'd0);
      rst_n = 1'b1;

      // Table: issue, count busy cycles and done pulses, check HI/LO
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b);
         @(negedge clk);
         op_valid = 1'b0;
         #1;
         cyc = 0; dn = 0; dlast = 0;
         while (busy1 && cyc < 200) begin
            cyc++;
            if (done1) begin dn++; dlast = cyc; end
            @(negedge clk);
            #1;
         end
         chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
         chk($sformatf("v%0d_done_cnt", i), 32'(dn), 32'd1);
         chk($sformatf("v%0d_done_at", i), 32'(dlast), 32'(vecs[i].cyc));
         chk($sformatf("v%0d_hi", i), hi1, vecs[i].hi);
         chk($sformatf("v%0d_lo", i), lo1, vecs[i].lo);
         chk($sformatf("v%0d_hi4", i), hi4, vecs[i].hi);
         chk($sformatf("v%0d_lo4", i), lo4, vecs[i].lo);
      end

      // MFLO held right after MULT 6*7: stall 33 (STEPS=1) / 9 (STEPS=4)
      drive(3'd0, 32'd6, 32'd7);
      @(negedge clk);
      op_code = 3'd7;
      #1;
      s1 = 0; s4 = 0; k = 0; got4 = 1'b0; mf4v = '0;
      while ((stall1 || stall4) && k < 100) begin
         k++;
         if (stall1) s1++;
         if (stall4) s4++;
         else if (!got4) begin got4 = 1'b1; mf4v = mf4; end
         @(negedge clk);
         #1;
      end
      if (!got4) mf4v = mf4;
      chk("mflo_stall1", 32'(s1), 32'd33);
      chk("mflo_stall4", 32'(s4), 32'd9);
      chk("mflo_mf1", mf1, 32'd42);
      chk("mflo_mf4", mf4v, 32'd42);
      op_valid = 1'b0;

      // Back-to-back: DIVU stalls through MULTU's FIXUP, accepted first IDLE
      drive(3'd1, 32'd3, 32'd5);
      @(negedge clk);
      op_code = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
      #1;
      s1 = 0; k = 0;
      while (stall1 && k < 100) begin
         k++; s1++;
         @(negedge clk);
         #1;
      end
      chk("b2b_stall", 32'(s1), 32'd33);
      chk("b2b_hi_mul", hi1, 32'd0);
      chk("b2b_lo_mul", lo1, 32'd15);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      chk("b2b_busy", {31'b0, busy1}, 32'd1);
      k = 0;
      while (busy1 && k < 100) begin
         k++;
         @(negedge clk);
         #1;
      end
      chk("b2b_hi_div", hi1, 32'd2);
      chk("b2b_lo_div", lo1, 32'd14);

      // Reset during DIVU at iteration 10 discards the operation
      drive(3'd3, 32'hFFFF_FFFF, 32'd3);
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (i == 0) op_valid = 1'b0;
         if (done1) dn++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst_busy", {31'b0, busy1}, 32'd0);
      chk("midrst_hi", hi1, 32'd0);
      chk("midrst_lo", lo1, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (done1) dn++;
         @(negedge clk);
         #1;
      end
      chk("midrst_no_done", 32'(dn), 32'd0);
      op_code = 3'd6;
      #1;
      chk("midrst_stall", {31'b0, stall1}, 32'd0);
      chk("midrst_mf", mf1, 32'd0);

      // MTHI then MFHI, MTLO then MFLO: no stall, zero added latency
      drive(3'd4, 32'h0000_00A5, 32'd0);
      drive(3'd6, 32'd0, 32'd0);
      chk("mfhi_data", mf1, 32'h0000_00A5);
      drive(3'd5, 32'h1357_9BDF, 32'd0);
      drive(3'd7, 32'd0, 32'd0);
      chk("mflo_data", mf1, 32'h1357_9BDF);
      op_code = 3'd0;
      #1;
      chk("mf_other_op", mf1, 32'd0);
      @(negedge clk);
      op_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer with the architectural HI/LO registers for the 5-stage MIPS pipeline. Decode issues MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO here; the block runs a multi-cycle shift-add multiply or restoring divide and owns HI/LO. It raises a stall back to decode whenever an issued HI/LO-touching instruction cannot be accepted.

## Interface
- STEPS, 1, iteration steps per cycle; legal values 1, 2, 4; N = 32/STEPS.
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- op_valid  in  1  decode presents a HI/LO op this cycle; the ID stage is not otherwise stalled.
- op_code  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- rs_data  in  32  forwarded rs: multiplicand, dividend, or MT source.
- rt_data  in  32  forwarded rt: multiplier or divisor.
- stall  out  1  op not accepted; decode holds it.
- busy  out  1  a mul/div is in flight.
- done  out  1  one-cycle pulse on the cycle HI/LO take a mul/div result.
- mf_data  out  32  HI (op 6) or LO (op 7); 0 for other op codes.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIXUP.
- Accept: op_valid & ~stall at a rising edge.
- stall = op_valid & (state != IDLE). This covers every op code, including MF/MT, so MF ops never read stale HI/LO and MT ops never race a result.
- IDLE, accept MTHI/MTLO: hi or lo <= rs_data; stay in IDLE.
- IDLE, accept MFHI/MFLO: no state change. mf_data is valid in the accept cycle; decode routes it into the ALU X operand.
- IDLE, accept MULT/MULTU:
  - Latch operand magnitudes: absolute values for signed ops, raw values for unsigned.
  - Latch neg_p = sign(rs) ^ sign(rt) for signed ops; 0 otherwise.
  - Clear the 64-bit accumulator and the step counter; go to MUL.
- IDLE, accept DIV/DIVU:
  - Latch magnitudes.
  - Latch neg_q = sign(rs) ^ sign(rt) and neg_r = sign(rs) for signed ops.
  - If rt_data == 0: go straight to FIXUP with the forced result HI = rs_data, LO = 0xFFFFFFFF. No iterations and no sign fixup.
  - Otherwise go to DIV.
- MUL: each cycle performs STEPS shift-add steps on {acc, multiplier}. After N cycles, go to FIXUP.
- DIV: each cycle performs STEPS restoring steps: shift the remainder left, subtract the divisor, and keep the difference if it is non-negative (quotient bit 1). After N cycles, go to FIXUP.
- FIXUP, result update at the edge ending FIXUP:
  - MUL: {hi, lo} <= neg_p ? -acc (64-bit two's complement) : acc.
  - DIV: lo <= neg_q ? -q : q; hi <= neg_r ? -r : r.
  - The next state is IDLE.
- All arithmetic is modulo 2^32 or 2^64. DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- The MF op that follows a mul/div stalls until the cycle after FIXUP, then reads the new value.

## Timing
- Reset (rst_n low at a rising edge): state IDLE; hi = lo = 0; busy = 0; done = 0. This holds even mid-operation; the in-flight operation is discarded.
- Combinational outputs after reset: stall = 0 and mf_data = 0.
- busy = (state != IDLE). It goes high the cycle after the mul/div accept.
- Mul/div occupancy is N + 1 cycles (N iterations plus FIXUP): 33 cycles for STEPS = 1, 9 cycles for STEPS = 4.
- Divide-by-zero occupancy is 1 cycle (FIXUP only).
- done is asserted during FIXUP. hi/lo show the result in the first IDLE cycle.
- stall is combinational from op_valid and registered state; there is no path from rs_data or rt_data to stall.
- mf_data is a combinational mux of the registered hi/lo.
- MT/MF ops have zero added latency when IDLE.
- Back-to-back mul/div: the second op stalls through FIXUP and is accepted in the first IDLE cycle.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (STEPS = 1) -> busy for 33 cycles, done pulse in the 33rd; HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT 0xFFFFFFFD (−3) × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
- DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 -> LO = 14, HI = 2. DIV 0x80000000 / −1 -> LO = 0x80000000, HI = 0.
- DIV 0x1234 / 0 -> busy for 1 cycle; HI = 0x00001234, LO = 0xFFFFFFFF.
- MFLO held valid the cycle after a MULT 6 × 7 accept -> stall high for exactly 33 cycles (STEPS = 1), then mf_data = 42 with stall = 0. Repeat with STEPS = 4 -> stall for 9 cycles.
- Reset and MT/MF path:
  - Start DIVU; drive rst_n low at iteration 10 -> next cycle busy = 0, hi = lo = 0, done never pulses.
  - Then MTHI 0xA5 followed by MFHI -> mf_data = 0xA5 with no stall.
